// File: rtl/uart_receiver.sv
// 8N1 UART receiver with oversampled bit recovery, byte counter and framing flag.
// Define RX_MAJORITY_EN for 3-sample majority voting per bit.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUDRATE   = 57600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data_in,
  input  logic       count_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] rx_count,
  output logic       busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
`ifdef RX_MAJORITY_EN
  localparam int START_PT = OVERSAMPLE / 2;
`else
  localparam int START_PT = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] START_LAST = SW'(START_PT);
  localparam logic [SW-1:0] SAMP_LAST  = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  logic          sync1_q;
  logic          sync2_q;
  logic          rx_s;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          bit_val;

  state_e        state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_data_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

`ifdef RX_MAJORITY_EN
  // Two previous tick samples; the current rx_s is the third vote.
  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vote_q <= 2'b11;
    end else if (tick) begin
      vote_q <= {vote_q[0], rx_s};
    end
  end

  assign bit_val = (vote_q[1] & vote_q[0]) |
                   (vote_q[1] & rx_s) |
                   (vote_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    cnt_d   = cnt_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            samp_d  = '0;
          end
        end
        START: begin
          if (samp_q == START_LAST) begin
            samp_d = '0;
            bit_d  = '0;
            state_d = bit_val ? IDLE : DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        DATA: begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            shift_d = {bit_val, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        STOP: begin
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            if (bit_val) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Clear beats a same-cycle increment.
    if (count_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_count  = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: tick-aligned 8N1 frames,
// byte scoreboard, counter/flag checks.
module tb_uart_receiver;

  localparam int OS     = 8;
  localparam int TD     = 3;
  localparam int BAUD   = 57600;
  localparam int CLK_HZ = TD * BAUD * OS;
`ifdef RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Stop-bit decision tick, counted from the tick that launches the start bit.
  localparam int EV = 1 + OS / 2 + 9 * OS + MAJ;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_data_in = 1'b1;
  logic       count_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] rx_count;
  logic       busy;

  int n_pass = 0;
  int n_tot = 0;
  int cyc = 0;
  int tph = 0;
  int n_ferr = 0;
  int valid_cyc = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] sb[$];

  uart_receiver #(
    .CLK_FREQ(CLK_HZ),
    .BAUDRATE(BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data_in(rx_data_in),
    .count_clr(count_clr),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .rx_count(rx_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) tph <= 0;
    else tph <= (tph == TD - 1) ? 0 : tph + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      check("valid_width", {31'd0, prev_valid}, 0);
      check("valid_ferr", {31'd0, frame_err}, 0);
      valid_cyc = cyc;
      if (sb.size() == 0) check("spurious_valid", {31'd0, rx_valid}, 0);
      else check("rx_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
    end
    if (frame_err) n_ferr++;
    prev_valid = rx_valid;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge clk); while (tph != 0 || reset);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int gbit);
    logic [7:0] e;
    e = b;
    if (gbit >= 0 && MAJ == 0) e[gbit] = 1'b0;
    if (stop) sb.push_back(e);
    start_cyc = cyc;
    rx_data_in = 1'b0;
    tick(OS);
    for (int k = 0; k < 8; k++) begin
      if (k == gbit) begin
        rx_data_in = 1'b1;
        tick(OS / 2);
        rx_data_in = 1'b0;
        tick(1);
        rx_data_in = 1'b1;
        tick(OS / 2 - 1);
      end else begin
        rx_data_in = b[k];
        tick(OS);
      end
    end
    rx_data_in = stop;
    tick(OS);
    if (!stop) tick(2 * OS);
    rx_data_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_count", {24'd0, rx_count}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    tick(2);

    send_frame(8'hA5, 1'b1, -1);
    check("a5_latency", valid_cyc - start_cyc, EV * TD);
    check("a5_count", {24'd0, rx_count}, 1);
    check("a5_ferr", n_ferr, 0);
    check("a5_sb", sb.size(), 0);
    check("a5_busy", {31'd0, busy}, 0);

    tick(2);
    rx_data_in = 1'b0;
    tick(2);
    check("fs_busy_hi", {31'd0, busy}, 1);
    tick(1);
    rx_data_in = 1'b1;
    tick(OS);
    check("fs_busy_lo", {31'd0, busy}, 0);
    check("fs_count", {24'd0, rx_count}, 1);
    check("fs_data", {24'd0, rx_data}, 8'hA5);

    do_reset();
    send_frame(8'h3C, 1'b0, -1);
    tick(2);
    check("fe_pulses", n_ferr, 1);
    check("fe_data", {24'd0, rx_data}, 0);
    check("fe_count", {24'd0, rx_count}, 0);
    check("fe_busy", {31'd0, busy}, 0);
    send_frame(8'h5A, 1'b1, -1);
    check("fe_5a_count", {24'd0, rx_count}, 1);
    check("fe_5a_pulses", n_ferr, 1);
    check("fe_5a_sb", sb.size(), 0);

    do_reset();
    send_frame(8'hFF, 1'b1, 2);
    check("gl_count", {24'd0, rx_count}, 1);
    check("gl_sb", sb.size(), 0);

    tick(2);
    rx_data_in = 1'b0;
    tick(OS);
    for (int k = 0; k < 4; k++) begin
      rx_data_in = 1'b1;
      tick(OS);
    end
    tick(OS / 2);
    check("mr_busy_pre", {31'd0, busy}, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mr_data", {24'd0, rx_data}, 0);
    check("mr_count", {24'd0, rx_count}, 0);
    check("mr_busy", {31'd0, busy}, 0);
    check("mr_valid", {31'd0, rx_valid}, 0);
    check("mr_ferr", {31'd0, frame_err}, 0);
    reset = 1'b0;
    tick(2 * OS);
    send_frame(8'h81, 1'b1, -1);
    check("mr_81_data", {24'd0, rx_data}, 8'h81);
    check("mr_81_count", {24'd0, rx_count}, 1);
    check("mr_81_sb", sb.size(), 0);

    do_reset();
    for (int i = 0; i < 257; i++) send_frame(8'(i), 1'b1, -1);
    check("wrap_count", {24'd0, rx_count}, 1);
    check("wrap_sb", sb.size(), 0);
    fork
      send_frame(8'h77, 1'b1, -1);
      begin
        tick(EV - 1);
        repeat (TD - 1) @(negedge clk);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        check("clr_valid", {31'd0, rx_valid}, 1);
      end
    join
    check("clr_count", {24'd0, rx_count}, 0);
    check("clr_sb", sb.size(), 0);
    check("final_ferr", n_ferr, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
